// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction fetch port and the load/store port.
// Define MEM_ARB_STATS_EN to add saturating fetch/data/stall activity counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_fetch,
    output logic [15:0]       stat_data,
    output logic [15:0]       stat_stall
`endif
);

    localparam int CNT_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t              r_state;
    logic                r_grantFetch;
    logic                r_we;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [CNT_W-1:0]    r_starveCnt;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;
    logic                r_memWe;
    logic                r_memRe;
    logic                r_ifAck;
    logic                r_dAck;
    logic [DATA_W-1:0]   r_ifRdata;
    logic [DATA_W-1:0]   r_dRdata;

    logic                w_starved;
    logic                w_fetchWins;
    logic                w_anyReq;

    // A waiting fetch overrides data priority only once the data port has had STARVE_MAX grants in a row.
    assign w_starved   = (STARVE_MAX > 0) && (r_starveCnt == CNT_W'(STARVE_MAX));
    assign w_fetchWins = if_req && (!d_req || w_starved);
    assign w_anyReq    = if_req || d_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grantFetch <= 1'b0;
            r_we         <= 1'b0;
            r_waitCnt    <= '0;
            r_starveCnt  <= '0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_memWe      <= 1'b0;
            r_memRe      <= 1'b0;
            r_ifAck      <= 1'b0;
            r_dAck       <= 1'b0;
            r_ifRdata    <= '0;
            r_dRdata     <= '0;
        end else begin
            r_memWe <= 1'b0;
            r_memRe <= 1'b0;
            r_ifAck <= 1'b0;
            r_dAck  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grantFetch <= w_fetchWins;
                        r_state      <= ISSUE;
                        if (w_fetchWins) begin
                            r_we        <= 1'b0;
                            r_memAddr   <= if_addr;
                            r_memRe     <= 1'b1;
                            r_starveCnt <= '0;
                        end else begin
                            r_we       <= d_we;
                            r_memAddr  <= d_addr;
                            r_memWdata <= d_wdata;
                            r_memWe    <= d_we;
                            r_memRe    <= !d_we;
                            if (!if_req) begin
                                r_starveCnt <= '0;
                            end else if (!w_starved) begin
                                r_starveCnt <= r_starveCnt + CNT_W'(1);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        r_dAck  <= 1'b1;
                        r_state <= ACK;
                    end else begin
                        r_waitCnt <= WAIT_W'(1);
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_waitCnt == WAIT_W'(MEM_LAT)) begin
                        if (r_grantFetch) begin
                            r_ifRdata <= mem_rdata;
                            r_ifAck   <= 1'b1;
                        end else begin
                            r_dRdata <= mem_rdata;
                            r_dAck   <= 1'b1;
                        end
                        r_state <= ACK;
                    end else begin
                        r_waitCnt <= r_waitCnt + WAIT_W'(1);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_ifAck;
    assign d_ack     = r_dAck;
    assign if_rdata  = r_ifRdata;
    assign d_rdata   = r_dRdata;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_we    = r_memWe;
    assign mem_re    = r_memRe;
    assign stall     = (if_req && !r_ifAck) || (d_req && !r_dAck);

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_statFetch;
    logic [15:0] r_statData;
    logic [15:0] r_statStall;

    // Counters stick at all-ones rather than wrapping so a long run never reads back as small.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_statFetch <= '0;
            r_statData  <= '0;
            r_statStall <= '0;
        end else begin
            if (r_ifAck && (r_statFetch != 16'hFFFF)) begin
                r_statFetch <= r_statFetch + 16'd1;
            end
            if (r_dAck && (r_statData != 16'hFFFF)) begin
                r_statData <= r_statData + 16'd1;
            end
            if (stall && (r_statStall != 16'hFFFF)) begin
                r_statStall <= r_statStall + 16'd1;
            end
        end
    end

    assign stat_fetch = r_statFetch;
    assign stat_data  = r_statData;
    assign stat_stall = r_statStall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 runs MEM_LAT=1/STARVE_MAX=3, instance 1 runs MEM_LAT=4.
// Stat counter checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;

    logic       ifReq    [2];
    logic [7:0] ifAddr   [2];
    logic       ifAck    [2];
    logic [7:0] ifRdata  [2];
    logic       dReq     [2];
    logic       dWe      [2];
    logic [7:0] dAddr    [2];
    logic [7:0] dWdata   [2];
    logic       dAck     [2];
    logic [7:0] dRdata   [2];
    logic [7:0] memAddr  [2];
    logic [7:0] memWdata [2];
    logic       memWe    [2];
    logic       memRe    [2];
    logic [7:0] memRdata [2];
    logic       stall    [2];
`ifdef MEM_ARB_STATS_EN
    logic [15:0] statFetch [2];
    logic [15:0] statData  [2];
    logic [15:0] statStall [2];
`endif

    int tests = 0;
    int fails = 0;
    int stallCycles = 0;

    logic [7:0] mem [256];
    logic [7:0] pipeA;
    logic [7:0] pipeB [4];

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(3)) dutA (
        .clock(clock), .reset(reset),
        .if_req(ifReq[0]), .if_addr(ifAddr[0]), .if_ack(ifAck[0]), .if_rdata(ifRdata[0]),
        .d_req(dReq[0]), .d_we(dWe[0]), .d_addr(dAddr[0]), .d_wdata(dWdata[0]),
        .d_ack(dAck[0]), .d_rdata(dRdata[0]),
        .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]), .mem_we(memWe[0]), .mem_re(memRe[0]),
        .mem_rdata(memRdata[0]), .stall(stall[0])
`ifdef MEM_ARB_STATS_EN
        , .stat_fetch(statFetch[0]), .stat_data(statData[0]), .stat_stall(statStall[0])
`endif
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(4), .STARVE_MAX(3)) dutB (
        .clock(clock), .reset(reset),
        .if_req(ifReq[1]), .if_addr(ifAddr[1]), .if_ack(ifAck[1]), .if_rdata(ifRdata[1]),
        .d_req(dReq[1]), .d_we(dWe[1]), .d_addr(dAddr[1]), .d_wdata(dWdata[1]),
        .d_ack(dAck[1]), .d_rdata(dRdata[1]),
        .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]), .mem_we(memWe[1]), .mem_re(memRe[1]),
        .mem_rdata(memRdata[1]), .stall(stall[1])
`ifdef MEM_ARB_STATS_EN
        , .stat_fetch(statFetch[1]), .stat_data(statData[1]), .stat_stall(statStall[1])
`endif
    );

    // Shared memory model: reloads known contents under reset; read data is only valid exactly MEM_LAT cycles after the strobe.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h05] <= 8'hA3;
            mem[8'h20] <= 8'h11;
            mem[8'h30] <= 8'h22;
            mem[8'hFF] <= 8'hC4;
        end else if (memWe[0]) begin
            mem[memAddr[0]] <= memWdata[0];
        end
        pipeA    <= memRe[0] ? mem[memAddr[0]] : 8'h00;
        pipeB[0] <= memRe[1] ? mem[memAddr[1]] : 8'h00;
        for (int i = 1; i < 4; i++) pipeB[i] <= pipeB[i-1];
    end

    assign memRdata[0] = pipeA;
    assign memRdata[1] = pipeB[3];

    // Stall of instance 0 is sampled just after the negedge drive, i.e. the value seen by the next posedge.
    always @(negedge clock) begin
        #2;
        if (reset) stallCycles = 0;
        else if (stall[0]) stallCycles = stallCycles + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Raises one request on instance u, waits (bounded) for its ack, checks the strobe, latency and read data.
    task automatic applyStimulus(input int u, input string tag, input bit isFetch, input bit we,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] expRdata, input int expLat);
        int n;
        bit seen;
        if (isFetch) begin
            ifReq[u]  = 1'b1;
            ifAddr[u] = addr;
        end else begin
            dReq[u]   = 1'b1;
            dWe[u]    = we;
            dAddr[u]  = addr;
            dWdata[u] = wdata;
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                checkOutput({tag, "_re"}, 32'(memRe[u]), 32'(isFetch || !we));
                checkOutput({tag, "_we"}, 32'(memWe[u]), 32'(!isFetch && we));
                checkOutput({tag, "_addr"}, 32'(memAddr[u]), 32'(addr));
                if (!isFetch && we) checkOutput({tag, "_wdata"}, 32'(memWdata[u]), 32'(wdata));
            end
            seen = isFetch ? ifAck[u] : dAck[u];
        end
        checkOutput({tag, "_lat"}, 32'(n), 32'(expLat));
        if (isFetch) begin
            checkOutput({tag, "_rdata"}, 32'(ifRdata[u]), 32'(expRdata));
            ifReq[u] = 1'b0;
        end else begin
            if (!we) checkOutput({tag, "_rdata"}, 32'(dRdata[u]), 32'(expRdata));
            dReq[u] = 1'b0;
        end
        @(negedge clock);
        checkOutput({tag, "_ackpulse"}, 32'(isFetch ? ifAck[u] : dAck[u]), 32'(0));
    endtask

    initial begin
        string order;
        string expOrder;
        int    cyc;
        int    acks;
        int    stallLow;

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ifReq[u] = 1'b0; ifAddr[u] = 8'h00;
            dReq[u]  = 1'b0; dWe[u] = 1'b0; dAddr[u] = 8'h00; dWdata[u] = 8'h00;
        end
        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            checkOutput($sformatf("rst%0d_ifAck", u), 32'(ifAck[u]), 32'(0));
            checkOutput($sformatf("rst%0d_dAck", u), 32'(dAck[u]), 32'(0));
            checkOutput($sformatf("rst%0d_memRe", u), 32'(memRe[u]), 32'(0));
            checkOutput($sformatf("rst%0d_memWe", u), 32'(memWe[u]), 32'(0));
            checkOutput($sformatf("rst%0d_stall", u), 32'(stall[u]), 32'(0));
        end
        reset = 1'b0;
        @(negedge clock);

        applyStimulus(0, "t1_fetch", 1'b1, 1'b0, 8'h05, 8'h00, 8'hA3, 3);
        applyStimulus(0, "t2_store", 1'b0, 1'b1, 8'h10, 8'h7E, 8'h00, 2);
        checkOutput("t2_mem10", 32'(mem[8'h10]), 32'h7E);

        // Both ports held busy: data wins three times, then the starved fetch gets one slot.
        ifReq[0] = 1'b1; ifAddr[0] = 8'h20;
        dReq[0]  = 1'b1; dWe[0] = 1'b0; dAddr[0] = 8'h30;
        order    = "";
        expOrder = "DDDFDDDF";
        cyc = 0; acks = 0; stallLow = 0;
        while (acks < 8 && cyc < 80) begin
            @(negedge clock);
            cyc++;
            if (stall[0] !== 1'b1) stallLow++;
            if (ifAck[0]) begin
                order = {order, "F"};
                acks++;
                checkOutput("t3_ifRdata", 32'(ifRdata[0]), 32'h11);
            end
            if (dAck[0]) begin
                order = {order, "D"};
                acks++;
                checkOutput("t3_dRdata", 32'(dRdata[0]), 32'h22);
            end
        end
        ifReq[0] = 1'b0;
        dReq[0]  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t3_grant%0d", i), 32'(order[i]), 32'(expOrder[i]));
        end
        checkOutput("t3_stallLow", 32'(stallLow), 32'(0));
        @(negedge clock);

        // Reset lands while a load sits in WAIT.
        dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 8'h30;
        @(negedge clock);
        checkOutput("t4_issueRe", 32'(memRe[0]), 32'(1));
        @(negedge clock);
        reset   = 1'b1;
        dReq[0] = 1'b0;
        #1;
        checkOutput("t4_dAck", 32'(dAck[0]), 32'(0));
        checkOutput("t4_memRe", 32'(memRe[0]), 32'(0));
        checkOutput("t4_memAddr", 32'(memAddr[0]), 32'(0));
        checkOutput("t4_dRdata", 32'(dRdata[0]), 32'(0));
        checkOutput("t4_ifRdata", 32'(ifRdata[0]), 32'(0));
        checkOutput("t4_stall", 32'(stall[0]), 32'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t4_noAck", 32'(dAck[0]), 32'(0));
        applyStimulus(0, "t4_fetch", 1'b1, 1'b0, 8'h05, 8'h00, 8'hA3, 3);

        applyStimulus(1, "t5_load", 1'b0, 1'b0, 8'hFF, 8'h00, 8'hC4, 6);
        applyStimulus(1, "t5_fetch", 1'b1, 1'b0, 8'h05, 8'h00, 8'hA3, 6);
        checkOutput("t5_hold", 32'(dRdata[1]), 32'hC4);
        applyStimulus(1, "t5_load2", 1'b0, 1'b0, 8'h30, 8'h00, 8'h22, 6);

        // Five fetches and three stores from a clean reset: 5*3 + 3*2 = 21 stall cycles.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
`ifdef MEM_ARB_STATS_EN
        checkOutput("t6_rstFetch", 32'(statFetch[0]), 32'(0));
`endif
        applyStimulus(0, "t6_f0", 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 3);
        applyStimulus(0, "t6_f1", 1'b1, 1'b0, 8'h01, 8'h00, 8'h5B, 3);
        applyStimulus(0, "t6_s0", 1'b0, 1'b1, 8'h40, 8'h01, 8'h00, 2);
        applyStimulus(0, "t6_f2", 1'b1, 1'b0, 8'h02, 8'h00, 8'h58, 3);
        applyStimulus(0, "t6_s1", 1'b0, 1'b1, 8'h41, 8'h02, 8'h00, 2);
        applyStimulus(0, "t6_f3", 1'b1, 1'b0, 8'h03, 8'h00, 8'h59, 3);
        applyStimulus(0, "t6_s2", 1'b0, 1'b1, 8'hFF, 8'h03, 8'h00, 2);
        applyStimulus(0, "t6_f4", 1'b1, 1'b0, 8'hFF, 8'h00, 8'h03, 3);
        repeat (2) @(negedge clock);
        checkOutput("t6_stallCycles", 32'(stallCycles), 32'd21);
`ifdef MEM_ARB_STATS_EN
        checkOutput("t6_statFetch", 32'(statFetch[0]), 32'd5);
        checkOutput("t6_statData", 32'(statData[0]), 32'd3);
        checkOutput("t6_statStall", 32'(statStall[0]), 32'd21);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
